// File: rtl/data_memory_io.sv
// Data memory with word RAM, memory-mapped output FIFO and status register.
// Optional cycle counter at 0xFFFF_0008 enabled by DMEM_CYCLE_COUNTER_EN.
module data_memory_io #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memw,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [29:0] PUSH_WORD = 30'h3FFF_C000;
    localparam logic [29:0] STAT_WORD = 30'h3FFF_C001;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [29:0]   word;
    logic [AW-1:0] ram_idx;
    logic          in_ram;
    logic          is_push;
    logic          is_stat;
    logic          unused_bits;

    assign word        = address[31:2];
    assign ram_idx     = address[AW+1:2];
    assign in_ram      = word < 30'(DEPTH);
    assign is_push     = word == PUSH_WORD;
    assign is_stat     = word == STAT_WORD;
    assign unused_bits = ^address[1:0];

    logic [31:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && memw && in_ram) begin
            ram[ram_idx] <= wdata;
        end
    end

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          ovf_set;
    logic          ovf_clr;

    assign full     = count == FULL_CNT;
    assign empty    = count == '0;
    assign out_valid = !empty;
    assign out_data = fifo_mem[head];

    assign pop      = out_valid && out_ready;
    assign push_req = memw && is_push;
    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = memw && is_stat && wdata[2];

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem[tail] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push_ok && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push_ok) begin
                count <= count - 1'b1;
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    localparam logic [29:0] CYC_WORD = 30'h3FFF_C002;

    logic [31:0] cycles;
    logic        is_cyc;

    assign is_cyc = word == CYC_WORD;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycles <= '0;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = ram[ram_idx];
        end else if (is_stat) begin
            rdata = {29'b0, overflow, full, empty};
        end else if (is_cyc) begin
            rdata = cycles;
        end
    end
`else
    always_comb begin
        rdata = '0;
        if (in_ram) begin
            rdata = ram[ram_idx];
        end else if (is_stat) begin
            rdata = {29'b0, overflow, full, empty};
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_io.sv
// Directed bench for data_memory_io: RAM, FIFO, status, reset and counter.
module tb_data_memory_io;

    logic        clk;
    logic        rst;
    logic        memw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;

    int checks;
    int failures;

    localparam logic [31:0] A_PUSH = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT = 32'hFFFF_0004;
    localparam logic [31:0] A_CYC  = 32'hFFFF_0008;

    data_memory_io #(.DEPTH(1024), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .memw      (memw),
        .address   (address),
        .wdata     (wdata),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d);
        memw    = w;
        address = a;
        wdata   = d;
    endtask

    task automatic rd(input logic [31:0] a);
        bus(1'b0, a, 32'h0);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        bus(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", out_valid);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h1) begin
            failures++;
            $display("FAIL reset_status got=%h want=00000001", rdata);
        end
    endtask

    task automatic test_ram();
        bus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        tick();
        bus(1'b1, 32'h0000_0000, 32'h1111_1111);
        tick();
        bus(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D);
        tick();
        bus(1'b1, 32'h0000_1000, 32'h2222_2222);
        tick();
        rd(32'h0000_0010);
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_read got=%h want=deadbeef", rdata);
        end
        rd(32'h0000_0013);
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_lowbits got=%h want=deadbeef", rdata);
        end
        rd(32'h0000_1010);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL ram_out_of_range got=%h want=0", rdata);
        end
        rd(32'h0000_0FFC);
        checks++;
        if (rdata !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL ram_last_word got=%h want=cafef00d", rdata);
        end
        rd(32'h0000_0000);
        checks++;
        if (rdata !== 32'h1111_1111) begin
            failures++;
            $display("FAIL ram_unmapped_write got=%h want=11111111", rdata);
        end
        rd(A_PUSH);
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL push_addr_read got=%h want=0", rdata);
        end
    endtask

    task automatic test_fifo_full();
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            bus(1'b1, A_PUSH, 32'(i));
            tick();
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'd1) begin
                    failures++;
                    $display("FAIL first_push got=%b/%h want=1/1", out_valid, out_data);
                end
            end
        end
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h2) begin
            failures++;
            $display("FAIL status_full got=%h want=2", rdata);
        end
        bus(1'b1, A_PUSH, 32'd99);
        tick();
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h6 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_push got=%h/%b want=6/1", rdata, overflow);
        end
        checks++;
        if (out_data !== 32'd1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL head_stable got=%h/%b want=1/1", out_data, out_valid);
        end
    endtask

    task automatic test_overflow_clear();
        bus(1'b1, A_STAT, 32'h3);
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL clear_bit2_zero got=%b want=1", overflow);
        end
        bus(1'b1, A_PUSH, 32'd77);
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_repeat got=%b want=1", overflow);
        end
        bus(1'b1, A_STAT, 32'h4);
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear got=%b want=0", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        out_ready = 1'b1;
        bus(1'b1, A_PUSH, 32'd9);
        tick();
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h2 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_full got=%h/%b want=2/0", rdata, overflow);
        end
        for (int i = 2; i <= 9; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
                failures++;
                $display("FAIL drain got=%b/%h want=1/%h", out_valid, out_data, 32'(i));
            end
            tick();
        end
        out_ready = 1'b0;
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drained_status got=%h/%b want=1/0", rdata, out_valid);
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(1'b1, A_PUSH, 32'h100 + 32'(i));
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h100) begin
            failures++;
            $display("FAIL queued got=%b/%h want=1/100", out_valid, out_data);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        bus(1'b1, 32'h0000_0010, 32'h5555_5555);
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        rd(A_STAT);
        checks++;
        if (rdata !== 32'h1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flush got=%h/%b want=1/0", rdata, out_valid);
        end
        rd(32'h0000_0010);
        checks++;
        if (rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL ram_kept got=%h want=deadbeef", rdata);
        end
        bus(1'b1, A_PUSH, 32'hABC);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hABC) begin
            failures++;
            $display("FAIL post_reset_push got=%b/%h want=1/abc", out_valid, out_data);
        end
    endtask

    task automatic test_cycles();
        logic [31:0] want;
`ifdef DMEM_CYCLE_COUNTER_EN
        want = 32'd5;
`else
        want = 32'd0;
`endif
        rst = 1'b1;
        bus(1'b0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        rd(A_CYC);
        checks++;
        if (rdata !== want) begin
            failures++;
            $display("FAIL cycles got=%0d want=%0d", rdata, want);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        memw     = 1'b0;
        address  = 32'h0;
        wdata    = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_ram();
        test_fifo_full();
        test_overflow_clear();
        test_push_pop_full();
        test_reset_flush();
        test_cycles();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_memory_io.md
DATA_MEMORY_IO -- requirements
Module: data_memory_io

Interface
REQ-001 Parameter DEPTH, default 1024, RAM size in 32-bit words (power of two).
REQ-002 Parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 memw  input  1  write enable from processor memory stage.
REQ-006 address  input  32  byte address from processor; bits [1:0] ignored.
REQ-007 wdata  input  32  store data from processor.
REQ-008 rdata  output  32  load data to processor memory/writeback register.
REQ-009 out_data  output  32  FIFO head word to external consumer.
REQ-010 out_valid  output  1  FIFO non-empty.
REQ-011 out_ready  input  1  consumer accepts head when high with out_valid.
REQ-012 overflow  output  1  sticky FIFO overflow flag.

Function
REQ-013 Address map: RAM at 0x0000_0000 to DEPTH*4-1; FIFO_PUSH at 0xFFFF_0000 (write-only); STATUS at 0xFFFF_0004; CYCLES at 0xFFFF_0008 (when configured); all else unmapped.
REQ-014 rdata is combinational from address in the same cycle, zero latency; processor samples it at the next edge.
REQ-015 RAM read returns word address[31:2] modulo DEPTH within the RAM range; no bypass needed since write commits at the edge.
REQ-016 RAM write commits wdata at rising edge when memw=1 and address is in RAM range.
REQ-017 STATUS read = {29'b0, overflow, full, empty}; FIFO_PUSH read and unmapped reads return 0.
REQ-018 Write to STATUS with wdata[2]=1 clears overflow; other bits ignored; unmapped writes have no effect.
REQ-019 Write to FIFO_PUSH when not full: push wdata at tail; out_valid rises the next cycle if the FIFO was empty.
REQ-020 Write to FIFO_PUSH when full and no pop the same cycle: data dropped, overflow set at the next edge.
REQ-021 Pop occurs when out_valid=1 and out_ready=1; head advances the next edge.
REQ-022 Simultaneous push and pop: both accepted, count unchanged, including when full; when empty only push takes effect.
REQ-023 out_data = head entry, registered storage; value undefined-but-stable when out_valid=0.
REQ-024 Head/tail pointers wrap modulo FIFO_DEPTH; count is clog2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
REQ-025 out_data/out_valid held stable while out_valid=1 and out_ready=0.
REQ-026 Overflow set and clear in the same cycle: set wins.

Reset
REQ-027 rst=1 at an edge: FIFO empty (pointers, count 0), out_valid=0, overflow=0, cycle counter 0.
REQ-028 RAM contents not affected by reset; writes and pushes in a reset cycle are discarded.
REQ-029 A pending pop at reset is discarded; FIFO contents lost.

Configuration
REQ-030 Macro DMEM_CYCLE_COUNTER_EN defined: 32-bit free-running counter, +1 per cycle, wraps 0xFFFF_FFFF->0, readable at CYCLES, writes ignored.
REQ-031 Macro undefined: no counter logic; CYCLES address is unmapped (reads 0).

Verification
REQ-032 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> rdata=0xDEADBEEF same cycle as address; read 0x0000_1010 (DEPTH=1024) -> 0.
REQ-033 Push 1..8 to 0xFFFF_0000 with out_ready=0 -> STATUS=0x2; 9th push -> data dropped, STATUS=0x6, overflow=1.
REQ-034 Full FIFO, push 9 with out_ready=1 same cycle -> pop 1, accept 9, STATUS=0x2; drain sequence 2..9, then STATUS=0x1.
REQ-035 Overflow=1, write 0x4 to 0xFFFF_0004 -> overflow=0 next cycle; same-cycle clear and overflow push -> overflow stays 1.
REQ-036 Three words queued, rst pulse one cycle -> out_valid=0, STATUS=0x1, RAM word previously written still reads back.
REQ-037 With DMEM_CYCLE_COUNTER_EN: read CYCLES 5 cycles after reset -> 5; without macro -> 0.
